// File: rtl/xrisc_mmio_uart_tx.sv
// xrisc_mmio_uart_tx: store-fed byte FIFO and 8N1 serializer on the core data bus.
// Define XRISC_UART_PARITY_EN to insert an even-parity bit between data and stop.
module xrisc_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        Hit,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        irq_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [NW-1:0] DEPTH    = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STAT_ADR = BASE_ADDR + 32'd4;

`ifdef XRISC_UART_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;
`else
  localparam logic PAR_FLAG = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef XRISC_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  logic push_req;
  logic clr_req;
  logic full;
  logic busy;
  logic pop;
  logic push_ok;
  logic last;
  logic unused_wdata;

  assign push_req = MemWrite && (DataAdr == BASE_ADDR);
  assign clr_req  = MemWrite && (DataAdr == STAT_ADR)
                    && WriteData[2];
  assign full     = (cnt_q == DEPTH);
  assign busy     = (state_q != S_IDLE) || (cnt_q != '0);
  // The serializer only drains in IDLE, and only bytes already counted.
  assign pop      = (state_q == S_IDLE) && (cnt_q != '0);
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push_ok  = push_req && (!full || pop);
  assign last     = (cyc_q == CYC_LAST);

  assign unused_wdata = ^WriteData[31:8];

  assign Hit      = (DataAdr[31:3] == BASE_ADDR[31:3]);
  assign ReadData = (DataAdr == STAT_ADR)
                    ? {28'b0, PAR_FLAG, ovf_q, full, busy}
                    : 32'b0;
  assign tx        = tx_q;
  assign irq_empty = irq_q;

  // FIFO pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (clr_req)
      ovf_d = 1'b0;
    else if (push_req && !push_ok)
      ovf_d = 1'b1;
  end

  // Serializer next-state: each slot lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
`ifdef XRISC_UART_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          sh_d    = mem_q[rd_ptr_q];
`ifdef XRISC_UART_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
          tx_d    = 1'b0;
          cyc_d   = '0;
          state_d = S_START;
        end else begin
          tx_d    = 1'b1;
        end
      end
      S_START: begin
        if (last) begin
          tx_d    = sh_q[0];
          bit_d   = 3'd0;
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d   = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (last) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
`ifdef XRISC_UART_PARITY_EN
            tx_d    = par_q;
            state_d = S_PAR;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`ifdef XRISC_UART_PARITY_EN
      S_PAR: begin
        if (last) begin
          tx_d    = 1'b1;
          cyc_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d   = cyc_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (last) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d   = cyc_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        cyc_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Interrupt tracks "nothing left to send" as of the coming edge.
  always_comb begin
    irq_d = (state_d == S_IDLE) && (cnt_d == '0);
  end

  // FIFO storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  // Control state register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= 3'd0;
      sh_q     <= 8'd0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef XRISC_UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef XRISC_UART_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule
